// File: rtl/traffic_ctrl_param_if.sv
// Purpose : bundles the control inputs and lamp/phase outputs of the
//           two-road intersection controller into one interface.
// Signals : tick, start, night, req1, req2   (controller inputs)
//           G1, Y1, R1, G2, Y2, R2            (lamp outputs, road 1 / road 2)
//           phase[2:0]                        (current state code)
// Modports: master - drives the inputs and observes the lamps (bench/host)
//           slave  - the controller itself
interface traffic_ctrl_param_if;
  logic       tick;
  logic       start;
  logic       night;
  logic       req1;
  logic       req2;
  logic       G1;
  logic       Y1;
  logic       R1;
  logic       G2;
  logic       Y2;
  logic       R2;
  logic [2:0] phase;

  modport master (
    output tick, start, night, req1, req2,
    input  G1, Y1, R1, G2, Y2, R2, phase
  );

  modport slave (
    input  tick, start, night, req1, req2,
    output G1, Y1, R1, G2, Y2, R2, phase
  );
endinterface

// File: rtl/traffic_ctrl_param.sv
// Purpose : parametrised two-road intersection controller with demand-based
//           green extension, safe start/stop, night flashing-yellow mode and
//           a visible phase code.
// Ports   : clk   - system clock
//           reset - asynchronous, active-high reset (forces IDLE, all-red)
//           bus   - traffic_ctrl_param_if.slave: tick/start/night/req1/req2 in,
//                   G1/Y1/R1/G2/Y2/R2 lamps and phase[2:0] out
// Params  : CNT_W    - phase down-counter width
//           T_GREEN  - minimum green duration in ticks
//           T_YELLOW - yellow duration in ticks
//           T_ALLRED - all-red clearance in ticks
module traffic_ctrl_param #(
  parameter int CNT_W    = 8,
  parameter int T_GREEN  = 20,
  parameter int T_YELLOW = 3,
  parameter int T_ALLRED = 1
) (
  input logic                 clk,
  input logic                 reset,
  traffic_ctrl_param_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRN1  = 3'd1,
    YEL1  = 3'd2,
    AR1   = 3'd3,
    GRN2  = 3'd4,
    YEL2  = 3'd5,
    AR2   = 3'd6,
    FLASH = 3'd7
  } state_t;

  // Counter load values: a phase of T ticks loads T-1 and expires on the
  // tick that finds the counter at zero.
  localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(T_GREEN  - 1);
  localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] LD_ALLRED = CNT_W'(T_ALLRED - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_blink;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_blink_nxt;
  logic             w_expire;

  logic w_G1, w_Y1, w_R1, w_G2, w_Y2, w_R2;

  assign w_expire = bus.tick && (r_cnt == '0);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_blink <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_blink <= w_blink_nxt;
    end
  end

  // Next-state / counter / blink logic
  always_comb begin
    w_state_nxt = r_state;
    w_blink_nxt = r_blink;
    // Free-running down-count on tick; it parks at zero once a phase has
    // expired so a held green simply waits for the exit condition.
    w_cnt_nxt   = (bus.tick && (r_cnt != '0)) ? (r_cnt - CNT_W'(1)) : r_cnt;

    if (bus.night && (r_state != FLASH)) begin
      // Night request pre-empts every phase immediately, tick or not.
      w_state_nxt = FLASH;
      w_blink_nxt = 1'b1;
      w_cnt_nxt   = '0;
    end else begin
      unique case (r_state)
        FLASH: begin
          if (bus.tick) w_blink_nxt = ~r_blink;
          // Leaving night mode passes through an all-red clearance that
          // hands over to road 1.
          if (!bus.night) begin
            w_state_nxt = AR2;
            w_cnt_nxt   = LD_ALLRED;
          end
        end
        IDLE: begin
          if (bus.start) begin
            w_state_nxt = GRN1;
            w_cnt_nxt   = LD_GREEN;
          end
        end
        GRN1: begin
          // Green is extended until the other road asks or we are stopping.
          if (w_expire && (bus.req2 || !bus.start)) begin
            w_state_nxt = YEL1;
            w_cnt_nxt   = LD_YELLOW;
          end
        end
        YEL1: begin
          if (w_expire) begin
            w_state_nxt = AR1;
            w_cnt_nxt   = LD_ALLRED;
          end
        end
        AR1: begin
          if (w_expire) begin
            if (bus.start) begin
              w_state_nxt = GRN2;
              w_cnt_nxt   = LD_GREEN;
            end else begin
              w_state_nxt = IDLE;
              w_cnt_nxt   = '0;
            end
          end
        end
        GRN2: begin
          if (w_expire && (bus.req1 || !bus.start)) begin
            w_state_nxt = YEL2;
            w_cnt_nxt   = LD_YELLOW;
          end
        end
        YEL2: begin
          if (w_expire) begin
            w_state_nxt = AR2;
            w_cnt_nxt   = LD_ALLRED;
          end
        end
        AR2: begin
          if (w_expire) begin
            if (bus.start) begin
              w_state_nxt = GRN1;
              w_cnt_nxt   = LD_GREEN;
            end else begin
              w_state_nxt = IDLE;
              w_cnt_nxt   = '0;
            end
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Lamp decode: pure function of state and blink
  always_comb begin
    w_G1 = 1'b0;
    w_Y1 = 1'b0;
    w_R1 = 1'b0;
    w_G2 = 1'b0;
    w_Y2 = 1'b0;
    w_R2 = 1'b0;
    unique case (r_state)
      GRN1:    begin w_G1 = 1'b1; w_R2 = 1'b1; end
      YEL1:    begin w_Y1 = 1'b1; w_R2 = 1'b1; end
      GRN2:    begin w_R1 = 1'b1; w_G2 = 1'b1; end
      YEL2:    begin w_R1 = 1'b1; w_Y2 = 1'b1; end
      FLASH:   begin w_Y1 = r_blink; w_Y2 = r_blink; end
      default: begin w_R1 = 1'b1; w_R2 = 1'b1; end
    endcase
  end

  assign bus.G1    = w_G1;
  assign bus.Y1    = w_Y1;
  assign bus.R1    = w_R1;
  assign bus.G2    = w_G2;
  assign bus.Y2    = w_Y2;
  assign bus.R2    = w_R2;
  assign bus.phase = r_state;

endmodule

// File: tb/tb_traffic_ctrl_param.sv
module tb_traffic_ctrl_param;

  localparam int CNT_W    = 8;
  localparam int T_GREEN  = 4;
  localparam int T_YELLOW = 2;
  localparam int T_ALLRED = 1;

  localparam logic [2:0] P_IDLE = 3'd0, P_GRN1 = 3'd1, P_YEL1 = 3'd2,
                         P_AR1  = 3'd3, P_GRN2 = 3'd4, P_YEL2 = 3'd5,
                         P_AR2  = 3'd6, P_FLASH = 3'd7;

  logic clk;
  logic reset;

  traffic_ctrl_param_if bus ();

  traffic_ctrl_param #(
    .CNT_W   (CNT_W),
    .T_GREEN (T_GREEN),
    .T_YELLOW(T_YELLOW),
    .T_ALLRED(T_ALLRED)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [2:0] ph;
    logic [5:0] lamps;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // Expected lamps {G1,Y1,R1,G2,Y2,R2} for a phase code
  function automatic logic [5:0] lamp_ref(input logic [2:0] ph, input logic bl);
    case (ph)
      P_GRN1:  return 6'b100_001;
      P_YEL1:  return 6'b010_001;
      P_GRN2:  return 6'b001_100;
      P_YEL2:  return 6'b001_010;
      P_FLASH: return {1'b0, bl, 1'b0, 1'b0, bl, 1'b0};
      default: return 6'b001_001;
    endcase
  endfunction

  task automatic expect_out(input string tag, input logic [2:0] ph, input logic bl);
    exp_t e;
    e.tag   = tag;
    e.ph    = ph;
    e.lamps = lamp_ref(ph, bl);
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t       e;
    logic [5:0] obs;
    if (sb.size() == 0) begin
      n_total = n_total + 1;
      $error("FAIL scoreboard_empty: observed phase %0d, required a queued expectation", bus.phase);
      return;
    end
    e   = sb.pop_front();
    obs = {bus.G1, bus.Y1, bus.R1, bus.G2, bus.Y2, bus.R2};
    n_total = n_total + 1;
    assert (bus.phase === e.ph) n_pass = n_pass + 1;
    else $error("FAIL %s phase: observed %0d, required %0d", e.tag, bus.phase, e.ph);
    n_total = n_total + 1;
    assert (obs === e.lamps) n_pass = n_pass + 1;
    else $error("FAIL %s lamps: observed %b, required %b", e.tag, obs, e.lamps);
    if (bus.phase !== P_FLASH) begin
      n_total = n_total + 1;
      assert (bus.R1 === 1'b1 || bus.R2 === 1'b1) n_pass = n_pass + 1;
      else $error("FAIL %s conflict: observed R1=%b R2=%b, required at least one red", e.tag, bus.R1, bus.R2);
    end
  endtask

  // One clock: inputs already set at this negedge take effect at the next
  // posedge; outputs are compared at the following negedge.
  task automatic step(input string tag, input logic [2:0] ph, input logic bl);
    expect_out(tag, ph, bl);
    @(negedge clk);
    check_out();
  endtask

  initial begin
    int durs [6];
    durs = '{T_GREEN, T_YELLOW, T_ALLRED, T_GREEN, T_YELLOW, T_ALLRED};

    reset     = 1'b1;
    bus.tick  = 1'b0;
    bus.start = 1'b0;
    bus.night = 1'b0;
    bus.req1  = 1'b0;
    bus.req2  = 1'b0;

    // Reset state
    step("reset", P_IDLE, 1'b0);
    reset = 1'b0;
    step("idle_no_start", P_IDLE, 1'b0);

    // Fixed cycle with demand on both roads, two full periods
    bus.tick  = 1'b1;
    bus.start = 1'b1;
    bus.req1  = 1'b1;
    bus.req2  = 1'b1;
    for (int rep = 0; rep < 2; rep++)
      for (int p = 0; p < 6; p++)
        for (int k = 0; k < durs[p]; k++)
          step("cycle", 3'(p + 1), 1'b0);

    // Green extension: no demand on road 2 holds GRN1 past its minimum
    bus.req2 = 1'b0;
    for (int k = 0; k < 10; k++) step("ext_grn1", P_GRN1, 1'b0);
    bus.req2 = 1'b1;
    step("ext_yel1", P_YEL1, 1'b0);
    step("ext_yel1", P_YEL1, 1'b0);
    step("ext_ar1",  P_AR1,  1'b0);
    step("ext_grn2", P_GRN2, 1'b0);

    // Stop one cycle into GRN2: full green, yellow, all-red, then IDLE
    bus.start = 1'b0;
    for (int k = 0; k < 3; k++) step("stop_grn2", P_GRN2, 1'b0);
    step("stop_yel2", P_YEL2, 1'b0);
    step("stop_yel2", P_YEL2, 1'b0);
    step("stop_ar2",  P_AR2,  1'b0);
    step("stop_idle", P_IDLE, 1'b0);
    step("stop_idle", P_IDLE, 1'b0);
    bus.start = 1'b1;
    step("restart_grn1", P_GRN1, 1'b0);
    step("restart_grn1", P_GRN1, 1'b0);

    // Night mode mid-GRN1
    bus.night = 1'b1;
    step("flash", P_FLASH, 1'b1);
    step("flash", P_FLASH, 1'b0);
    step("flash", P_FLASH, 1'b1);
    step("flash", P_FLASH, 1'b0);
    bus.night = 1'b0;
    step("night_ar2",  P_AR2,  1'b0);
    step("night_grn1", P_GRN1, 1'b0);

    // Slow tick (every 3rd clk) from a fresh reset
    reset    = 1'b1;
    bus.tick = 1'b0;
    step("slow_reset", P_IDLE, 1'b0);
    reset = 1'b0;
    step("slow_entry", P_GRN1, 1'b0);
    for (int c = 1; c <= 22; c++) begin
      bus.tick = (c % 3 == 0);
      if (c < 12)      step("slow_grn1", P_GRN1, 1'b0);
      else if (c < 18) step("slow_yel1", P_YEL1, 1'b0);
      else if (c < 21) step("slow_ar1",  P_AR1,  1'b0);
      else             step("slow_grn2", P_GRN2, 1'b0);
    end

    // Async reset mid-YEL2, between clock edges
    bus.tick = 1'b1;
    for (int k = 0; k < 3; k++) step("pre_grn2", P_GRN2, 1'b0);
    step("pre_yel2", P_YEL2, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    expect_out("async_reset", P_IDLE, 1'b0);
    check_out();
    bus.start = 1'b0;
    @(negedge clk);
    step("held_reset", P_IDLE, 1'b0);
    reset = 1'b0;
    step("post_reset_idle", P_IDLE, 1'b0);
    step("post_reset_idle", P_IDLE, 1'b0);
    bus.start = 1'b1;
    step("post_reset_grn1", P_GRN1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
